// File: rtl/iso_rx_pkg.sv
// Shared definitions for the single-lane isochronous receive deframer.
package iso_rx_pkg;

  localparam logic [7:0] K_BS = 8'hBC;
  localparam logic [7:0] K_SR = 8'h1C;
  localparam logic [7:0] K_BE = 8'hFB;
  localparam logic [7:0] K_FS = 8'hFE;
  localparam logic [7:0] K_FE = 8'hF7;
  localparam logic [7:0] K_SS = 8'h5C;
  localparam logic [7:0] K_SE = 8'hFD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_BLANK,
    ST_ACTIVE,
    ST_FILL,
    ST_SDP
  } iso_rx_state_e;

  // Number of header copies carried on one lane: fewer lanes, more repetition.
  function automatic logic [2:0] rep_from_lane_count(input logic [1:0] lane_count);
    case (lane_count)
      2'b00:   rep_from_lane_count = 3'd4;
      2'b01:   rep_from_lane_count = 3'd2;
      default: rep_from_lane_count = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/iso_rx_hdr_capture.sv
// Blanking-header capture: latches the first {VB-ID, Mvid, Maud} copy and
// compares all later copies against it.
module iso_rx_hdr_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       capture,
  input  logic [7:0] data,
  input  logic [2:0] rep,
  output logic       done,
  output logic       mismatch,
  output logic [7:0] vbid,
  output logic [7:0] mvid,
  output logic [7:0] maud
);

  logic [1:0] fld_q;
  logic [1:0] copy_q;
  logic [7:0] vbid_q;
  logic [7:0] mvid_q;
  logic [7:0] maud_q;
  logic       mis_q;
  logic [7:0] stored;
  logic       first_copy;

  // Outputs include the symbol being captured this cycle, so the top can
  // load the fields on the same clock as the final header symbol.
  always_comb begin
    first_copy = (copy_q == 2'd0);
    case (fld_q)
      2'd0:    stored = vbid_q;
      2'd1:    stored = mvid_q;
      default: stored = maud_q;
    endcase
    done     = capture && (fld_q == 2'd2) && ({1'b0, copy_q} == rep - 3'd1);
    mismatch = mis_q | (capture && !first_copy && (data != stored));
    vbid     = (capture && first_copy && fld_q == 2'd0) ? data : vbid_q;
    mvid     = (capture && first_copy && fld_q == 2'd1) ? data : mvid_q;
    maud     = (capture && first_copy && fld_q == 2'd2) ? data : maud_q;
  end

  // Field/copy index tracking, first-copy storage and sticky mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fld_q  <= '0;
      copy_q <= '0;
      vbid_q <= '0;
      mvid_q <= '0;
      maud_q <= '0;
      mis_q  <= 1'b0;
    end else if (start) begin
      fld_q  <= '0;
      copy_q <= '0;
      mis_q  <= 1'b0;
    end else if (capture) begin
      mis_q  <= mismatch;
      vbid_q <= vbid;
      mvid_q <= mvid;
      maud_q <= maud;
      if (fld_q == 2'd2) begin
        fld_q  <= '0;
        copy_q <= copy_q + 2'd1;
      end else begin
        fld_q <= fld_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/iso_rx_lane_deframer.sv
// Sink-side single-lane isochronous deframer: framing recovery, header
// capture and separation of pixel and secondary-packet bytes.
module iso_rx_lane_deframer
  import iso_rx_pkg::*;
#(
  parameter int unsigned BYTE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            td_lane_count,
  input  logic [7:0]            iso_symbols,
  input  logic                  iso_control_sym_flag,
  output logic [7:0]            rx_pixel_byte,
  output logic                  rx_pixel_vld,
  output logic [7:0]            rx_sdp_byte,
  output logic                  rx_sdp_vld,
  output logic [7:0]            rx_vbid,
  output logic [7:0]            rx_mvid,
  output logic [7:0]            rx_maud,
  output logic                  rx_hdr_vld,
  output logic                  rx_line_end,
  output logic [BYTE_CNT_W-1:0] rx_line_bytes,
  output logic                  rx_locked,
  output logic                  rx_err
);

  iso_rx_state_e         state;
  logic [2:0]            rep_q;
  logic [BYTE_CNT_W-1:0] cnt_q;
  logic                  is_k;
  logic                  is_bs;
  logic                  bad_k;
  logic                  hdr_capture;
  logic                  hdr_done;
  logic                  hdr_mis;
  logic [7:0]            hdr_vbid;
  logic [7:0]            hdr_mvid;
  logic [7:0]            hdr_maud;

  // Symbol classification; bad_k flags any K that is not legal in the current state.
  always_comb begin
    is_k        = iso_control_sym_flag;
    is_bs       = is_k && (iso_symbols == K_BS || iso_symbols == K_SR);
    hdr_capture = (state == ST_HDR) && !is_k;
    bad_k       = 1'b0;
    if (is_k && !is_bs) begin
      case (state)
        ST_IDLE:   bad_k = 1'b0;
        ST_BLANK:  bad_k = !(iso_symbols == K_BE || iso_symbols == K_SS);
        ST_ACTIVE: bad_k = (iso_symbols != K_FS);
        ST_FILL:   bad_k = (iso_symbols != K_FE);
        ST_SDP:    bad_k = (iso_symbols != K_SE);
        default:   bad_k = 1'b1;
      endcase
    end
  end

  iso_rx_hdr_capture u_hdr (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (is_bs),
    .capture  (hdr_capture),
    .data     (iso_symbols),
    .rep      (rep_q),
    .done     (hdr_done),
    .mismatch (hdr_mis),
    .vbid     (hdr_vbid),
    .mvid     (hdr_mvid),
    .maud     (hdr_maud)
  );

  // Deframing FSM with byte counter and registered outputs.
  // BS/SR is handled ahead of the per-state case because it restarts the
  // header from every state; only its side effects differ per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rep_q         <= '0;
      cnt_q         <= '0;
      rx_pixel_byte <= '0;
      rx_pixel_vld  <= 1'b0;
      rx_sdp_byte   <= '0;
      rx_sdp_vld    <= 1'b0;
      rx_vbid       <= '0;
      rx_mvid       <= '0;
      rx_maud       <= '0;
      rx_hdr_vld    <= 1'b0;
      rx_line_end   <= 1'b0;
      rx_line_bytes <= '0;
      rx_locked     <= 1'b0;
      rx_err        <= 1'b0;
    end else begin
      rx_pixel_vld <= 1'b0;
      rx_sdp_vld   <= 1'b0;
      rx_hdr_vld   <= 1'b0;
      rx_line_end  <= 1'b0;
      rx_err       <= 1'b0;
      if (is_bs) begin
        state <= ST_HDR;
        rep_q <= rep_from_lane_count(td_lane_count);
        if (state == ST_ACTIVE || state == ST_FILL) begin
          rx_line_end   <= 1'b1;
          rx_line_bytes <= cnt_q;
        end
        if (state == ST_SDP) rx_err <= 1'b1;
      end else if (bad_k) begin
        state     <= ST_IDLE;
        rx_err    <= 1'b1;
        rx_locked <= 1'b0;
      end else begin
        case (state)
          ST_HDR: begin
            if (hdr_done) begin
              state      <= ST_BLANK;
              rx_vbid    <= hdr_vbid;
              rx_mvid    <= hdr_mvid;
              rx_maud    <= hdr_maud;
              rx_hdr_vld <= 1'b1;
              rx_locked  <= 1'b1;
              rx_err     <= hdr_mis;
            end
          end
          ST_BLANK: begin
            if (is_k && iso_symbols == K_SS) begin
              state <= ST_SDP;
            end else if (is_k && !(rx_vbid[0] || rx_vbid[3])) begin
              state <= ST_ACTIVE;
              cnt_q <= '0;
            end
          end
          ST_ACTIVE: begin
            if (is_k) begin
              state <= ST_FILL;
            end else begin
              rx_pixel_byte <= iso_symbols;
              rx_pixel_vld  <= 1'b1;
              if (cnt_q != '1) cnt_q <= cnt_q + BYTE_CNT_W'(1);
            end
          end
          ST_FILL: begin
            if (is_k) state <= ST_ACTIVE;
          end
          ST_SDP: begin
            if (is_k) begin
              state <= ST_BLANK;
            end else begin
              rx_sdp_byte <= iso_symbols;
              rx_sdp_vld  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
